// File: rtl/cs_trgt_pkg.sv
// ============================================================================
//  Module      : cs_trgt_pkg
//  Description : Shared types, defaults and width helper for the target-side
//                co-simulation bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cs_trgt_pkg;

    localparam int c_n_ch_default     = 3;
    localparam int c_dw_default       = 8;
    localparam int c_depth_default    = 4;
    localparam int c_wdog_cyc_default = 1024;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        STARVED = 1'b1
    } cs_chan_st_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD    = 2'd1,
        BLOCKED = 2'd2
    } cs_ul_st_e;

    // Never returns zero, so a one-entry range still gets a 1-bit vector.
    function automatic int cs_clog2(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cs_trgt_fifo.sv
// ============================================================================
//  Module      : cs_trgt_fifo
//  Description : Per-channel download FIFO; pointers carry a wrap bit so full
//                and empty need no separate counter. No write-to-read bypass.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cs_trgt_fifo
    import cs_trgt_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_aw = cs_clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cs_trgt_bridge.sv
// ============================================================================
//  Module      : cs_trgt_bridge
//  Description : Target-side co-sim bridge: buffered download channels drive
//                the DUT one word per mission-clock event, the upload path
//                captures DUT outputs, and starved/blocked clocks are frozen.
//                Optional starvation watchdog: define CS_TRGT_WDOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cs_trgt_bridge
    import cs_trgt_pkg::*;
#(
    parameter int N_CH     = c_n_ch_default,
    parameter int DW       = c_dw_default,
    parameter int DEPTH    = c_depth_default,
    parameter int WDOG_CYC = c_wdog_cyc_default
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      dl_valid_i,
    output logic                      dl_ready_o,
    input  logic [cs_clog2(N_CH)-1:0] dl_ch_i,
    input  logic [DW:0]               dl_data_i,
    input  logic [N_CH:0]             evt_i,
    output logic [N_CH:0]             freeze_clk_o,
    output logic [N_CH-1:0]           dut_wen_o,
    output logic [N_CH*DW-1:0]        dut_data_o,
    input  logic                      dut_valid_i,
    input  logic [DW-1:0]             dut_data_i,
    output logic                      ul_valid_o,
    input  logic                      ul_ready_i,
    output logic [DW:0]               ul_data_o,
    output logic                      err_o
);

    localparam int c_chw = cs_clog2(N_CH);
`ifdef CS_TRGT_WDOG_EN
    localparam int          c_cw       = cs_clog2(WDOG_CYC);
    localparam logic [c_cw-1:0] c_wdog_lim = c_cw'(WDOG_CYC - 1);
`endif

    logic [N_CH-1:0] w_full;
    logic [N_CH-1:0] w_frz_ch;
    logic [N_CH-1:0] w_to_ch;
    logic            w_to_ul;

    // Out-of-range channel numbers never match, so they are never accepted.
    always_comb begin
        dl_ready_o = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (dl_ch_i == c_chw'(c)) dl_ready_o = !w_full[c];
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        cs_chan_st_e r_st;
        logic        r_frz;
        logic        r_wen;
        logic [DW-1:0] r_data;
        logic        w_push;
        logic        w_pop;
        logic        w_empty;
        logic [DW:0] w_rdata;

        assign w_push = dl_valid_i && dl_ready_o && (dl_ch_i == c_chw'(c));
        assign w_pop  = !w_empty && ((r_st == RUN && evt_i[c]) || r_st == STARVED);

        cs_trgt_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (DW + 1)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .i_push  (w_push),
            .i_wdata (dl_data_i),
            .i_pop   (w_pop),
            .o_rdata (w_rdata),
            .o_full  (w_full[c]),
            .o_empty (w_empty)
        );

`ifdef CS_TRGT_WDOG_EN
        logic [c_cw-1:0] r_cnt;
        assign w_to_ch[c] = (r_st == STARVED) && !w_pop && (r_cnt == c_wdog_lim);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)                          r_cnt <= '0;
            else if (r_st == STARVED && !w_pop && !w_to_ch[c]) r_cnt <= r_cnt + 1'b1;
            else                                  r_cnt <= '0;
        end
`else
        assign w_to_ch[c] = 1'b0;
`endif

        // A ready word always wins over a watchdog expiry in the same cycle.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_st   <= RUN;
                r_frz  <= 1'b0;
                r_wen  <= 1'b0;
                r_data <= '0;
            end else if (w_pop) begin
                r_wen  <= w_rdata[DW];
                r_data <= w_rdata[DW-1:0];
                r_frz  <= 1'b0;
                r_st   <= RUN;
            end else if (r_st == RUN && evt_i[c]) begin
                r_frz  <= 1'b1;
                r_st   <= STARVED;
            end else if (w_to_ch[c]) begin
                r_frz  <= 1'b0;
                r_st   <= RUN;
            end
        end

        assign w_frz_ch[c]              = r_frz;
        assign dut_wen_o[c]             = r_wen;
        assign dut_data_o[c*DW +: DW]   = r_data;
    end

    cs_ul_st_e r_ul_st;
    logic      r_ul_frz;
    logic      r_ul_valid;
    logic [DW:0] r_ul_data;

`ifdef CS_TRGT_WDOG_EN
    logic [c_cw-1:0] r_ul_cnt;
    logic            r_err;
    assign w_to_ul = (r_ul_st == BLOCKED) && !ul_ready_i && (r_ul_cnt == c_wdog_lim);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ul_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_ul_st == BLOCKED && !ul_ready_i && !w_to_ul) r_ul_cnt <= r_ul_cnt + 1'b1;
            else                                                r_ul_cnt <= '0;
            if (w_to_ul || (|w_to_ch)) r_err <= 1'b1;
        end
    end
    assign err_o = r_err;
`else
    assign w_to_ul = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ul_st    <= IDLE;
            r_ul_frz   <= 1'b0;
            r_ul_valid <= 1'b0;
            r_ul_data  <= '0;
        end else begin
            case (r_ul_st)
                IDLE: begin
                    if (evt_i[N_CH]) begin
                        r_ul_data  <= {dut_valid_i, dut_data_i};
                        r_ul_valid <= 1'b1;
                        r_ul_st    <= HELD;
                    end
                end
                HELD: begin
                    if (ul_ready_i && evt_i[N_CH]) begin
                        r_ul_data  <= {dut_valid_i, dut_data_i};
                    end else if (ul_ready_i) begin
                        r_ul_valid <= 1'b0;
                        r_ul_st    <= IDLE;
                    end else if (evt_i[N_CH]) begin
                        r_ul_frz   <= 1'b1;
                        r_ul_st    <= BLOCKED;
                    end
                end
                BLOCKED: begin
                    // DUT outputs are stable here because the upload clock is held.
                    if (ul_ready_i || w_to_ul) begin
                        r_ul_data  <= {dut_valid_i, dut_data_i};
                        r_ul_frz   <= 1'b0;
                        r_ul_st    <= HELD;
                    end
                end
                default: begin
                    r_ul_st <= IDLE;
                end
            endcase
        end
    end

    assign freeze_clk_o = {r_ul_frz, w_frz_ch};
    assign ul_valid_o   = r_ul_valid;
    assign ul_data_o    = r_ul_data;

endmodule

`default_nettype wire

// File: doc/cs_trgt_bridge.md
Name: cs_trgt_bridge

Overview:
- Parametrised, synthesizable target-side co-simulation bridge for partitioned-design runs.
- Buffers words downloaded from the initiator transport into per-channel FIFOs and applies one word to the DUT inputs per mission-clock event.
- Captures DUT outputs on the upload event and offers them to the transport.
- Freezes any mission clock whose data is not yet available (download) or not yet consumed (upload). Sits between the shunt transport adapter and the partitioned DUT.

Parameters:
- N_CH, 3, number of download channels; mission clock c = channel c; clock N_CH = upload clock.
- DW, 8, DUT data width per channel.
- DEPTH, 4, per-channel FIFO depth (power of 2, >=2).
- WDOG_CYC, 1024, starvation timeout in clk_i cycles (used only with the optional feature).

Ports:
- clk_i  in  1  utility clock
- rst_ni  in  1  asynchronous active-low reset
- dl_valid_i  in  1  download word valid
- dl_ready_o  out  1  download accepted; combinational, = !full[dl_ch_i]
- dl_ch_i  in  $clog2(N_CH)  target channel
- dl_data_i  in  DW+1  {wen, data}
- evt_i  in  N_CH+1  single-cycle mission-clock event strobes, clk_i domain
- freeze_clk_o  out  N_CH+1  hold mission clock n
- dut_wen_o  out  N_CH  per-channel write enable to DUT
- dut_data_o  out  N_CH*DW  per-channel data, channel c at [c*DW +: DW]
- dut_valid_i  in  1  DUT output valid
- dut_data_i  in  DW  DUT output data
- ul_valid_o  out  1  upload word valid
- ul_ready_i  in  1  upload consumed
- ul_data_o  out  DW+1  {valid, o_data}
- err_o  out  1  sticky watchdog error (tied 0 when the feature is off)

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFOs empty, all channel FSMs in RUN.
- Push: dl_valid_i && dl_ready_o writes dl_data_i into FIFO[dl_ch_i]. dl_ch_i >= N_CH is never accepted (dl_ready_o=0).
- The word becomes poppable the cycle after push; there is no bypass.
- Channel FSM c, RUN:
  - evt_i[c] with FIFO non-empty: pop; {dut_wen_o[c], dut_data_o[c]} update at t+1.
  - evt_i[c] with FIFO empty: go to STARVED; freeze_clk_o[c]=1 from t+1.
- Channel FSM c, STARVED:
  - First cycle the FIFO is non-empty: pop, update outputs, freeze_clk_o[c]=0, return to RUN (all in the same registered edge).
  - evt_i[c] while STARVED is ignored; the clock is frozen, so this is a source error.
- Outputs hold their last value between events. wen is held as well, not pulsed.
- Push and pop on the same full FIFO in the same cycle: pop occurs; dl_ready_o stays 0 (full is evaluated pre-pop).
- Pointers are $clog2(DEPTH)+1 bits with wrap bit; full/empty are derived from the wrap bit.
- Upload FSM, states IDLE / HELD / BLOCKED:
  - IDLE: evt_i[N_CH] captures {dut_valid_i, dut_data_i} into ul_data_o; ul_valid_o=1 at t+1; go to HELD.
  - HELD: ul_ready_i → ul_valid_o=0 and go to IDLE. If evt_i[N_CH] arrives in the same cycle as ul_ready_i, capture the new word and stay in HELD.
  - HELD with evt_i[N_CH] and no ul_ready_i: freeze_clk_o[N_CH]=1, go to BLOCKED.
  - BLOCKED: on ul_ready_i, capture current DUT outputs (stable, clock frozen), keep ul_valid_o=1, release freeze, go to HELD.
- Reset mid-operation: FIFO contents are lost and freezes release immediately (async).

Optional Feature:
- Macro: CS_TRGT_WDOG_EN.
- Defined:
  - A per-FSM counter runs while in STARVED or BLOCKED.
  - When it reaches WDOG_CYC-1, err_o sets (sticky until reset), the freeze releases and the FSM returns to RUN/HELD.
  - Channel outputs keep their old value; for upload, the word in flight is overwritten by a fresh capture.
- Undefined: no counters; err_o=0; freezes last indefinitely.

Decomposition:
- Package cs_trgt_pkg:
  - cs_chan_st_e {RUN, STARVED}
  - cs_ul_st_e {IDLE, HELD, BLOCKED}
  - function clog2-safe width helper
  - default parameter constants
- Sub-module cs_trgt_fifo (DEPTH x DW+1, push/pop/full/empty), instantiated N_CH times in a generate loop.

Test Plan:
- Push ch0 0x1A5, then evt_i[0] → dut_wen_o[0]=1, dut_data_o[0]=0xA5 one cycle later; freeze_clk_o=0.
- evt_i[1] with FIFO1 empty → freeze_clk_o[1]=1 next cycle; push ch1 0x03C 5 cycles later → freeze drops and data=0x3C at push+2.
- Push 4 words to ch2 → dl_ready_o=0 with dl_ch_i=2; push pop-same-cycle on full → count stays 3 after pop; wrap over 10 words preserves order.
- Upload: evt_i[3] with dut={1,0x5A} → ul_data_o=0x15A; second evt without ul_ready_i → freeze_clk_o[3]=1; ul_ready_i → new capture, freeze=0.
- Assert rst_ni low while ch0 STARVED with 2 words in FIFO1 → freeze_clk_o=0 immediately, all outputs 0, FIFOs empty after release.
- With CS_TRGT_WDOG_EN, WDOG_CYC=16: ch0 starved 16 cycles → err_o=1, freeze_clk_o[0]=0, dut_data_o[0] unchanged.
